// File: rtl/fpu_bank_pkg.sv
// Shared types and default sizing for the FPU bank dispatcher.
// op_id_t mirrors the FPU op encoding so descriptors pass through unchanged.
package fpu_bank_pkg;
  localparam int NUM_FPU_DEF     = 4;
  localparam int QUEUE_DEPTH_DEF = 8;
  localparam int TAG_W_DEF       = 4;
  localparam int ADDR_W_DEF      = 23;

  typedef enum logic [2:0] {
    OP_NOOP = 3'd0,
    OP_ADD  = 3'd1,
    OP_MUL  = 3'd2,
    OP_FMA  = 3'd3,
    OP_DIV  = 3'd4,
    OP_SQRT = 3'd5
  } op_id_t;

  // Operand regions indexed 0..3 = a, b, c, d.
  typedef struct packed {
    op_id_t                          op;
    logic [TAG_W_DEF-1:0]            tag;
    logic [3:0][ADDR_W_DEF-1:0]      region_begin;
    logic [3:0][ADDR_W_DEF-1:0]      region_end;
  } job_desc_t;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_RUN    = 2'd1,
    CH_RETIRE = 2'd2
  } ch_state_t;
endpackage

// File: rtl/fpu_job_queue.sv
// Power-of-two FIFO holding pending job descriptors; head is valid when count_o != 0.
module fpu_job_queue #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       data_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;
  logic           do_push, do_pop;

  assign do_push = push_i && (cnt_q != (PW+1)'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/fpu_bank_dispatch.sv
// Queues FPU jobs and hands them round-robin to idle channels, reporting one completion per job.
// Define FPU_BANK_PERF_EN to add saturating busy-cycle and completed-job counters.
module fpu_bank_dispatch
  import fpu_bank_pkg::*;
#(
  parameter int NUM_FPU     = NUM_FPU_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  localparam int CH_W       = (NUM_FPU > 1) ? $clog2(NUM_FPU) : 1,
  localparam int QC_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid_i,
  output logic                        job_ready_o,
  input  job_desc_t                   job_desc_i,
  output logic [NUM_FPU-1:0]          ch_avail_o,
  output job_desc_t [NUM_FPU-1:0]     ch_desc_o,
  input  logic [NUM_FPU-1:0]          ch_done_i,
  output logic                        cmpl_valid_o,
  output logic [TAG_W-1:0]            cmpl_tag_o,
  output logic [CH_W-1:0]             cmpl_ch_o,
  output logic [QC_W-1:0]             q_count_o,
  output logic                        idle_o
`ifdef FPU_BANK_PERF_EN
  ,
  output logic [31:0]                 perf_busy_cycles_o,
  output logic [31:0]                 perf_jobs_done_o
`endif
);
  // Descriptor layout is fixed in the package, so only the default widths are legal.
  if (TAG_W != TAG_W_DEF || ADDR_W != ADDR_W_DEF) begin : g_cfg_chk
    $error("fpu_bank_dispatch: TAG_W/ADDR_W must match fpu_bank_pkg");
  end

  ch_state_t [NUM_FPU-1:0] st_q, st_d;
  logic      [NUM_FPU-1:0] rep_q, rep_d;
  job_desc_t [NUM_FPU-1:0] desc_q, desc_d;
  logic      [CH_W-1:0]    rr_q, rr_d;
  logic                    cmpl_valid_q;
  logic      [TAG_W-1:0]   cmpl_tag_q, cmpl_tag_d;
  logic      [CH_W-1:0]    cmpl_ch_q, cmpl_ch_d;

  job_desc_t               q_head;
  logic      [QC_W-1:0]    q_count;
  logic                    q_push, q_pop;
  logic                    disp_found, gnt_vld;
  logic      [CH_W-1:0]    disp_ch, gnt_ch;
  int                      j;

  assign job_ready_o = (q_count < QC_W'(QUEUE_DEPTH));
  assign q_push      = job_valid_i && job_ready_o;
  assign q_pop       = disp_found && (q_count != '0);

  fpu_job_queue #(.DEPTH(QUEUE_DEPTH), .T(job_desc_t)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .data_i  (job_desc_i),
    .head_o  (q_head),
    .count_o (q_count)
  );

  // Search idle channels starting at the round-robin pointer; lowest-index retiring channel reports.
  always_comb begin
    disp_found = 1'b0;
    disp_ch    = '0;
    gnt_vld    = 1'b0;
    gnt_ch     = '0;
    j          = 0;
    for (int off = 0; off < NUM_FPU; off++) begin
      j = int'(rr_q) + off;
      if (j >= NUM_FPU) j = j - NUM_FPU;
      if (!disp_found && st_q[j] == CH_IDLE) begin
        disp_found = 1'b1;
        disp_ch    = CH_W'(j);
      end
    end
    for (int i = 0; i < NUM_FPU; i++) begin
      if (!gnt_vld && st_q[i] == CH_RETIRE && !rep_q[i]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
  end

  always_comb begin
    st_d       = st_q;
    rep_d      = rep_q;
    desc_d     = desc_q;
    rr_d       = rr_q;
    cmpl_tag_d = cmpl_tag_q;
    cmpl_ch_d  = cmpl_ch_q;
    if (q_pop) rr_d = (disp_ch == CH_W'(NUM_FPU - 1)) ? '0 : disp_ch + 1'b1;
    if (gnt_vld) begin
      cmpl_tag_d = TAG_W'(desc_q[gnt_ch].tag);
      cmpl_ch_d  = gnt_ch;
    end
    for (int i = 0; i < NUM_FPU; i++) begin
      case (st_q[i])
        CH_IDLE: if (q_pop && disp_ch == CH_W'(i)) begin
          st_d[i]   = CH_RUN;
          desc_d[i] = q_head;
        end
        CH_RUN: if (ch_done_i[i]) st_d[i] = CH_RETIRE;
        CH_RETIRE: begin
          if (gnt_vld && gnt_ch == CH_W'(i)) rep_d[i] = 1'b1;
          // Leave only once reported and the job manager has dropped done.
          if (rep_d[i] && !ch_done_i[i]) begin
            st_d[i]  = CH_IDLE;
            rep_d[i] = 1'b0;
          end
        end
        default: st_d[i] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= {NUM_FPU{CH_IDLE}};
      rep_q        <= '0;
      desc_q       <= '0;
      rr_q         <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_tag_q   <= '0;
      cmpl_ch_q    <= '0;
    end else begin
      st_q         <= st_d;
      rep_q        <= rep_d;
      desc_q       <= desc_d;
      rr_q         <= rr_d;
      cmpl_valid_q <= gnt_vld;
      cmpl_tag_q   <= cmpl_tag_d;
      cmpl_ch_q    <= cmpl_ch_d;
    end
  end

  always_comb begin
    ch_avail_o = '0;
    idle_o     = (q_count == '0);
    for (int i = 0; i < NUM_FPU; i++) begin
      ch_avail_o[i] = (st_q[i] == CH_RUN);
      if (st_q[i] != CH_IDLE) idle_o = 1'b0;
    end
  end

  assign ch_desc_o    = desc_q;
  assign cmpl_valid_o = cmpl_valid_q;
  assign cmpl_tag_o   = cmpl_tag_q;
  assign cmpl_ch_o    = cmpl_ch_q;
  assign q_count_o    = q_count;

`ifdef FPU_BANK_PERF_EN
  logic [31:0] perf_busy_q, perf_jobs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_jobs_q <= '0;
    end else begin
      if ((|ch_avail_o) && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 1'b1;
      if (gnt_vld && perf_jobs_q != '1)       perf_jobs_q <= perf_jobs_q + 1'b1;
    end
  end
  assign perf_busy_cycles_o = perf_busy_q;
  assign perf_jobs_done_o   = perf_jobs_q;
`endif
endmodule

// File: tb/tb_fpu_bank_dispatch.sv
// Directed-vector bench for fpu_bank_dispatch (default NUM_FPU=4, QUEUE_DEPTH=8).
module tb_fpu_bank_dispatch;
  import fpu_bank_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            job_valid = 1'b0;
  logic            job_ready;
  job_desc_t       job_desc = '0;
  logic [3:0]      ch_avail;
  job_desc_t [3:0] ch_desc;
  logic [3:0]      ch_done = '0;
  logic            cmpl_valid;
  logic [3:0]      cmpl_tag;
  logic [1:0]      cmpl_ch;
  logic [3:0]      q_count;
  logic            idle;
`ifdef FPU_BANK_PERF_EN
  logic [31:0]     perf_busy, perf_jobs;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fpu_bank_dispatch dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_desc_i(job_desc),
    .ch_avail_o(ch_avail), .ch_desc_o(ch_desc), .ch_done_i(ch_done),
    .cmpl_valid_o(cmpl_valid), .cmpl_tag_o(cmpl_tag), .cmpl_ch_o(cmpl_ch),
    .q_count_o(q_count), .idle_o(idle)
`ifdef FPU_BANK_PERF_EN
    , .perf_busy_cycles_o(perf_busy), .perf_jobs_done_o(perf_jobs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then read 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; job_valid = 1'b0; ch_done = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] tag, input op_id_t op);
    job_desc = '0;
    job_desc.op = op;
    job_desc.tag = tag;
    job_desc.region_begin[0] = {19'd0, tag};
    job_desc.region_end[3]   = 23'h7fffff;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic pulse_done(input int c);
    ch_done[c] = 1'b1;
    tick();
    ch_done[c] = 1'b0;
  endtask

  int order[4] = '{3, 1, 2, 0};

  initial begin
    do_reset();
    chk("rst_avail", ch_avail, 0);
    chk("rst_desc0", ch_desc == '0, 1);
    chk("rst_cmplv", cmpl_valid, 0);
    chk("rst_cmpltag", cmpl_tag, 0);
    chk("rst_cmplch", cmpl_ch, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", job_ready, 1);

    // Single NOOP job, tag 3.
    push(4'd3, OP_NOOP);
    chk("s_q1", q_count, 1);
    chk("s_avail_e1", ch_avail, 0);
    tick();
    chk("s_avail_e2", ch_avail, 4'b0001);
    chk("s_desc_tag", ch_desc[0].tag, 3);
    chk("s_desc_rgn", ch_desc[0].region_begin[0], 3);
    chk("s_busy", idle, 0);
    pulse_done(0);
    chk("s_retire_avail", ch_avail, 0);
    chk("s_retire_nocmpl", cmpl_valid, 0);
    tick();
    chk("s_cmplv", cmpl_valid, 1);
    chk("s_cmpltag", cmpl_tag, 3);
    chk("s_cmplch", cmpl_ch, 0);
    chk("s_idle", idle, 1);
    tick();
    chk("s_cmpl_oneshot", cmpl_valid, 0);

    // Fill: 9 pushes with done held low, then refill to full.
    do_reset();
    for (int t = 0; t < 9; t++) push(t[3:0], OP_ADD);
    chk("f_q5", q_count, 5);
    chk("f_avail", ch_avail, 4'hF);
    push(4'd9, OP_MUL); push(4'd10, OP_MUL);
    chk("f_q7", q_count, 7);
    chk("f_ready7", job_ready, 1);
    push(4'd11, OP_MUL);
    chk("f_q8", q_count, 8);
    chk("f_ready8", job_ready, 0);
    job_valid = 1'b1; job_desc.tag = 4'd12;
    tick();
    job_valid = 1'b0;
    chk("f_blocked", q_count, 8);
    pulse_done(0);
    tick();
    chk("f_cmpltag", cmpl_tag, 0);
    chk("f_cmplv", cmpl_valid, 1);
    tick();
    chk("f_q_after", q_count, 7);
    chk("f_ready_after", job_ready, 1);
    chk("f_redisp", ch_desc[0].tag, 4);

    // Tags 0..7, done returned in channel order 3,1,2,0 twice.
    do_reset();
    for (int t = 0; t < 8; t++) push(t[3:0], OP_FMA);
    chk("r_q4", q_count, 4);
    for (int c = 0; c < 4; c++) chk($sformatf("r_rr%0d", c), ch_desc[c].tag, c);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        pulse_done(order[k]);
        tick();
        chk($sformatf("r_cmplv%0d_%0d", r, k), cmpl_valid, 1);
        chk($sformatf("r_tag%0d_%0d", r, k), cmpl_tag, (r == 0) ? order[k] : 4 + k);
        chk($sformatf("r_ch%0d_%0d", r, k), cmpl_ch, order[k]);
        tick();
        if (r == 0) chk($sformatf("r_new%0d", k), ch_desc[order[k]].tag, 4 + k);
      end
    end
    chk("r_idle", idle, 1);

    // Simultaneous done on channels 1 and 2.
    do_reset();
    push(4'd5, OP_ADD); push(4'd6, OP_ADD); push(4'd7, OP_ADD);
    tick();
    chk("d_avail", ch_avail, 4'b0111);
    ch_done = 4'b0110;
    tick();
    ch_done = '0;
    tick();
    chk("d_first_v", cmpl_valid, 1);
    chk("d_first_ch", cmpl_ch, 1);
    chk("d_first_tag", cmpl_tag, 6);
    tick();
    chk("d_second_v", cmpl_valid, 1);
    chk("d_second_ch", cmpl_ch, 2);
    chk("d_second_tag", cmpl_tag, 7);
    tick();
    chk("d_quiet", cmpl_valid, 0);

    // Reset mid-job: 3 channels running, channel 3 parked in RETIRE, 2 queued.
    do_reset();
    for (int t = 0; t < 4; t++) push(t[3:0], OP_DIV);
    tick();
    ch_done[3] = 1'b1;
    tick(); tick();
    chk("x_parked_cmpl", cmpl_tag, 3);
    push(4'd4, OP_SQRT); push(4'd5, OP_SQRT);
    chk("x_q2", q_count, 2);
    chk("x_avail", ch_avail, 4'b0111);
    rst = 1'b1;
    tick();
    chk("x_avail_rst", ch_avail, 0);
    chk("x_q_rst", q_count, 0);
    chk("x_idle_rst", idle, 1);
    chk("x_ready_rst", job_ready, 1);
    chk("x_cmplv_rst", cmpl_valid, 0);
    chk("x_desc_rst", ch_desc == '0, 1);
    rst = 1'b0;
    tick();
    chk("x_done_idle_ignored", idle, 1);
    chk("x_no_cmpl", cmpl_valid, 0);
    ch_done = '0;
    push(4'd9, OP_ADD);
    tick();
    chk("x_rr_reset", ch_avail, 4'b0001);

`ifdef FPU_BANK_PERF_EN
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push(4'(r), OP_ADD);
      tick();
      repeat (9) tick();
      pulse_done(r);
      tick(); tick();
    end
    chk("p_busy", perf_busy, 20);
    chk("p_jobs", perf_jobs, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_bank_dispatch.md
FPU_BANK_DISPATCH -- requirements
Module: fpu_bank_dispatch

Interface
REQ-001 Parameter NUM_FPU, 4, number of FPU job-manager channels (1..8).
REQ-002 Parameter QUEUE_DEPTH, 8, job FIFO entries (power of two, >=2).
REQ-003 Parameter TAG_W, 4, job tag width.
REQ-004 Parameter ADDR_W, 23, memory region address width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 job_valid  input  1  job descriptor offered.
REQ-008 job_ready  output  1  queue can accept; a job transfers when job_valid && job_ready.
REQ-009 job_desc  input  job_desc_t  op (op_id), tag (TAG_W), region_begin/region_end for operands a,b,c,d (8 x ADDR_W).
REQ-010 ch_avail  output  NUM_FPU  per-channel job-start strobe level, held until that channel's done.
REQ-011 ch_desc  output  NUM_FPU x job_desc_t  descriptor for each channel, stable while ch_avail high.
REQ-012 ch_done  input  NUM_FPU  per-channel completion from job manager.
REQ-013 cmpl_valid  output  1  one-cycle completion pulse.
REQ-014 cmpl_tag  output  TAG_W  tag of completed job.
REQ-015 cmpl_ch  output  $clog2(NUM_FPU)  channel that completed it.
REQ-016 q_count  output  $clog2(QUEUE_DEPTH)+1  jobs waiting in queue.
REQ-017 idle  output  1  queue empty and all channels IDLE.

Function
REQ-018 Queue: FIFO; job_ready = (q_count < QUEUE_DEPTH); simultaneous push and pop when full is not allowed (ready low); push and pop in same cycle otherwise leaves q_count unchanged; pointers wrap modulo QUEUE_DEPTH.
REQ-019 Per-channel FSM: IDLE -> RUN (on dispatch) -> RETIRE (ch_done seen in RUN) -> IDLE (ch_done low and retirement reported).
REQ-020 ch_avail = 1 only in RUN; ch_desc loaded on dispatch edge and held until next dispatch.
REQ-021 Dispatch: at most one job per cycle, queue head to lowest-index IDLE channel after round-robin pointer; pointer advances past the chosen channel.
REQ-022 Dispatch latency: a job pushed into an empty queue with an IDLE channel reaches RUN on the 2nd rising edge after acceptance (1 cycle in queue).
REQ-023 A channel entering IDLE is not eligible for dispatch until the following cycle.
REQ-024 Completion: one cmpl_valid pulse per job, asserted the cycle after the channel enters RETIRE; if several channels are in RETIRE, lowest index reports first, others wait.
REQ-025 Queue empty: no dispatch, channels untouched; all channels busy: head waits, job_ready still per REQ-018.
REQ-026 ch_done asserted while channel IDLE is ignored.
REQ-027 Op NOOP: dispatched normally; completion depends solely on ch_done.

Reset
REQ-028 rst asserted: queue emptied, all FSMs IDLE, ch_avail=0, ch_desc=0, cmpl_valid=0, cmpl_tag=0, cmpl_ch=0, q_count=0, idle=1, job_ready=1, round-robin pointer=0.
REQ-029 Reset mid-job drops in-flight jobs without completion pulses.

Configuration
REQ-030 Macro FPU_BANK_PERF_EN defined: adds outputs perf_busy_cycles[31:0] (cycles any channel in RUN) and perf_jobs_done[31:0] (cmpl_valid count), both saturating, cleared by rst; undefined: outputs and counters absent, all other behaviour identical.

Structure
REQ-031 job_desc_t, channel state enum, and default parameter constants live in package fpu_bank_pkg; op_id is reused from the FPU defines.
REQ-032 FIFO is sub-module fpu_job_queue (parametrised by DEPTH, payload type).

Verification
REQ-033 Single job tag 3, NUM_FPU=4: ch_avail[0] rises 2 edges after accept; ch_done[0] pulsed -> cmpl_valid with tag 3, ch 0, then idle=1.
REQ-034 Push 9 jobs with all ch_done held low, QUEUE_DEPTH=8: 4 dispatched, queue reaches 5 then refills; job_ready low exactly when q_count=8.
REQ-035 Tags 0..7 back to back, done returned in channel order 3,1,2,0: cmpl_tag sequence follows retirement order, round-robin pointer rotates 0,1,2,3.
REQ-036 ch_done[1] and ch_done[2] rise same cycle: cmpl_ch 1 then 2 on consecutive cycles.
REQ-037 rst asserted with 3 channels in RUN and 2 queued: next cycle all outputs at reset values, no cmpl_valid.
REQ-038 With FPU_BANK_PERF_EN, 2 jobs of 10 RUN cycles each, non-overlapping: perf_busy_cycles=20, perf_jobs_done=2.
